interrupt_controller: RTL

- Receives the one-cycle interrupt pulses from the timer, LCD, serial and joypad blocks.
- Latches them into IF (0xFF0F), masks them with IE (0xFFFF), and presents the highest-priority pending request and its vector to the CPU.
- Runs a request/acknowledge handshake with the CPU core and clears the serviced IF bit on acknowledge.
- Sits on the memory-mapped IO bus beside the timer; IF and IE addresses come from the shared memory-map defines.

---
 rtl/interrupt_controller_pkg.sv | 22 ++
 rtl/interrupt_controller_prio_enc.sv | 22 ++
 rtl/interrupt_controller.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: IO addresses of IF/IE,
// source index constants and the handshake state encoding.
package interrupt_controller_pkg;

  localparam logic [15:0] IC_ADDR_IF = 16'hFF0F;
  localparam logic [15:0] IC_ADDR_IE = 16'hFFFF;

  localparam int IC_NUM_SRC = 5;

  localparam int INT_VBLANK = 0;
  localparam int INT_LCDC   = 1;
  localparam int INT_TIMER  = 2;
  localparam int INT_SERIAL = 3;
  localparam int INT_JOYPAD = 4;

  typedef enum logic [1:0] {
    IC_IDLE  = 2'd0,
    IC_REQ   = 2'd1,
    IC_ACKED = 2'd2
  } ic_state_t;

endpackage

// File: rtl/interrupt_controller_prio_enc.sv
// Combinational priority encoder: reports whether any request is pending and
// the lowest set index (index 0 is the highest priority).
module int_priority_encoder
  import interrupt_controller_pkg::*;
#(
  parameter int N = IC_NUM_SRC
) (
  input  logic [N-1:0] i_pending,
  output logic         o_valid,
  output logic [2:0]   o_idx
);

  // Scan from the low-priority end so the lowest set index is the one left standing.
  always_comb begin
    o_valid = |i_pending;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_pending[i]) o_idx = 3'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: latches source pulses into IF, masks them with IE,
// presents the highest-priority pending request and its vector to the CPU,
// and clears the serviced IF bit on acknowledge.
// Build option: define INTR_CTRL_EDGE_DETECT_EN to register the sources and
// set IF only on a rising edge (one extra cycle from source to IF).
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          NUM_SRC       = IC_NUM_SRC,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int          VECTOR_STRIDE = 8
) (
  input  logic        I_CLOCK,
  input  logic        I_RESET,
  input  logic        I_VBLANK_INT,
  input  logic        I_LCDC_INT,
  input  logic        I_TIMER_INT,
  input  logic        I_SERIAL_INT,
  input  logic        I_JOYPAD_INT,
  input  logic [15:0] I_ADDR,
  inout  wire  [7:0]  IO_DATA,
  input  logic        I_RE_L,
  input  logic        I_WE_L,
  output logic        O_INT_REQ,
  output logic [15:0] O_INT_VECTOR,
  input  logic        I_INT_ACK,
  output logic [7:0]  O_IF_DATA,
  output logic [7:0]  O_IE_DATA
);

  ic_state_t          r_state;
  ic_state_t          w_state_nxt;
  logic [NUM_SRC-1:0] r_if;
  logic [NUM_SRC-1:0] w_if_nxt;
  logic [7:0]         r_ie;
  logic [2:0]         r_sel;
  logic [15:0]        r_vector;

  logic [NUM_SRC-1:0] w_src;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_pending;
  logic [NUM_SRC-1:0] w_sel_mask;
  logic [NUM_SRC-1:0] w_clr_mask;
  logic               w_win_valid;
  logic [2:0]         w_win_idx;
  logic               w_sel_live;
  logic               w_load_sel;
  logic               w_ack_clr;
  logic               w_if_hit;
  logic               w_ie_hit;
  logic               w_if_wr;
  logic               w_ie_wr;
  logic               w_rd_en;
  logic [7:0]         w_rd_data;

  function automatic logic [15:0] vector_of(input logic [2:0] idx);
    return VECTOR_BASE + 16'(VECTOR_STRIDE * int'(idx));
  endfunction

  assign w_src[INT_VBLANK] = I_VBLANK_INT;
  assign w_src[INT_LCDC]   = I_LCDC_INT;
  assign w_src[INT_TIMER]  = I_TIMER_INT;
  assign w_src[INT_SERIAL] = I_SERIAL_INT;
  assign w_src[INT_JOYPAD] = I_JOYPAD_INT;

`ifdef INTR_CTRL_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] r_src_q1;
  logic [NUM_SRC-1:0] r_src_q2;

  // Keep the registered source and its previous sample so only a 0->1 transition sets IF.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      r_src_q1 <= '0;
      r_src_q2 <= '0;
    end else begin
      r_src_q1 <= w_src;
      r_src_q2 <= r_src_q1;
    end
  end

  assign w_set = r_src_q1 & ~r_src_q2;
`else
  assign w_set = w_src;
`endif

  assign w_if_hit = (I_ADDR == IC_ADDR_IF);
  assign w_ie_hit = (I_ADDR == IC_ADDR_IE);
  assign w_if_wr  = ~I_WE_L & w_if_hit;
  assign w_ie_wr  = ~I_WE_L & w_ie_hit;

  // IE bits above the source count are storage only and never reach the encoder.
  assign w_pending = r_if & r_ie[NUM_SRC-1:0];

  int_priority_encoder #(
    .N (NUM_SRC)
  ) u_prio (
    .i_pending (w_pending),
    .o_valid   (w_win_valid),
    .o_idx     (w_win_idx)
  );

  assign w_sel_mask = NUM_SRC'(1) << r_sel;
  assign w_sel_live = |(w_pending & w_sel_mask);
  assign w_clr_mask = w_ack_clr ? w_sel_mask : '0;

  // State register for the request/acknowledge handshake.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) r_state <= IC_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state: ack wins over a software cancel seen in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IC_IDLE:  if (w_win_valid) w_state_nxt = IC_REQ;
      IC_REQ: begin
        if (I_INT_ACK)        w_state_nxt = IC_ACKED;
        else if (!w_sel_live) w_state_nxt = IC_IDLE;
      end
      IC_ACKED: if (!I_INT_ACK) w_state_nxt = IC_IDLE;
      default:  w_state_nxt = IC_IDLE;
    endcase
  end

  // Outputs and control strobes decoded from the current state.
  always_comb begin
    O_INT_REQ  = 1'b0;
    w_load_sel = 1'b0;
    w_ack_clr  = 1'b0;
    case (r_state)
      IC_IDLE: w_load_sel = w_win_valid;
      IC_REQ: begin
        O_INT_REQ = 1'b1;
        w_ack_clr = I_INT_ACK;
      end
      default: ;
    endcase
  end

  // Capture the winner once on entry to REQ; a later higher-priority bit does not steal it.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      r_sel    <= '0;
      r_vector <= '0;
    end else if (w_load_sel) begin
      r_sel    <= w_win_idx;
      r_vector <= vector_of(w_win_idx);
    end
  end

  // IF next value: write or ack-clear forms the base, then source sets are OR-ed on top.
  always_comb begin
    w_if_nxt = w_if_wr ? IO_DATA[NUM_SRC-1:0] : (r_if & ~w_clr_mask);
    w_if_nxt = w_if_nxt | w_set;
  end

  // IF and IE storage.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      r_if <= '0;
      r_ie <= '0;
    end else begin
      r_if <= w_if_nxt;
      if (w_ie_wr) r_ie <= IO_DATA;
    end
  end

  assign w_rd_en   = ~I_RE_L & (w_if_hit | w_ie_hit);
  assign w_rd_data = w_if_hit ? {{(8 - NUM_SRC){1'b1}}, r_if} : r_ie;
  assign IO_DATA   = w_rd_en ? w_rd_data : 8'hzz;

  assign O_INT_VECTOR = r_vector;
  assign O_IF_DATA    = {{(8 - NUM_SRC){1'b1}}, r_if};
  assign O_IE_DATA    = r_ie;

endmodule
